// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Signed divides run on magnitudes; the quotient and remainder signs are fixed up in FIX.
module seq_divider #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
  localparam logic           SIGNED_ON = (SIGNED_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_div_by_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_sgn;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  assign w_sgn      = signed_op & SIGNED_ON;
  assign w_div_zero = (divisor == '0);
  assign w_dvd_mag  = (w_sgn & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag  = (w_sgn & divisor[WIDTH-1]) ? -divisor : divisor;

  // r_dq holds the dividend magnitude and fills with quotient bits from the right
  assign w_shift    = {r_rem, r_dq[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_ge       = ~w_trial[WIDTH];
  assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_final  = r_neg_q ? -r_dq : r_dq;
  assign w_r_final  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = w_div_zero ? S_FIX : S_CALC;
      S_CALC:  if (r_count == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_raw         <= '0;
      r_dq          <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg_q <= w_sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= w_sgn & dividend[WIDTH-1];
            r_dbz   <= w_div_zero;
            r_raw   <= dividend;
            r_dq    <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_dq    <= {r_dq[WIDTH-2:0], w_ge};
          r_count <= r_count + CW'(1);
        end
        S_FIX: begin
          r_done        <= 1'b1;
          r_div_by_zero <= r_dbz;
          r_quotient    <= r_dbz ? '1 : w_q_final;
          r_remainder   <= r_dbz ? r_raw : w_r_final;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - table, random and corner-sequence bench for seq_divider
// Two instances: 32-bit signed-capable and 8-bit unsigned-only.
module tb_seq_divider;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear;
  logic        s_start, s_signed_op;
  logic [31:0] s_dividend, s_divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        e_start, e_signed_op;
  logic [7:0]  e_dividend, e_divisor;
  logic        e_busy, e_done, e_dbz;
  logic [7:0]  e_q, e_r;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
    .clock(clock), .clear(clear), .start(s_start), .signed_op(s_signed_op),
    .dividend(s_dividend), .divisor(s_divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(0)) u_dut8 (
    .clock(clock), .clear(clear), .start(e_start), .signed_op(e_signed_op),
    .dividend(e_dividend), .divisor(e_divisor), .busy(e_busy), .done(e_done),
    .quotient(e_q), .remainder(e_r), .div_by_zero(e_dbz)
  );

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model32(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
    end else begin
      if (sop) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = a; sb = b;
      end
      tq = sa / sb; tr = sa % sb;
      q = tq[31:0]; r = tr[31:0]; dbz = 1'b0;
    end
  endtask

  task automatic run32(input string name, input logic sop, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat);
    int k, nb;
    logic held_bad;
    logic [31:0] q0, r0;
    logic d0;
    @(negedge clock);
    s_start = 1'b1; s_signed_op = sop; s_dividend = a; s_divisor = b;
    @(negedge clock);
    s_start = 1'b0; s_signed_op = 1'($urandom); s_dividend = $urandom; s_divisor = $urandom;
    k = 0; nb = 0; held_bad = 1'b0;
    q0 = quotient; r0 = remainder; d0 = div_by_zero;
    while (!done && k < 200) begin
      if (busy) nb++;
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== d0) held_bad = 1'b1;
      @(negedge clock);
      k++;
    end
    check({name, ".lat"}, k, elat);
    check({name, ".q"}, quotient, eq);
    check({name, ".r"}, remainder, er);
    check({name, ".dbz"}, div_by_zero, edbz);
    check({name, ".busy_cycles"}, nb, elat);
    check({name, ".held"}, held_bad, 1'b0);
  endtask

  task automatic run8(input string name, input logic sop, input logic [7:0] a,
                      input logic [7:0] b);
    int k;
    logic [7:0] eq, er;
    logic edbz;
    int elat;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edbz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; elat = 9;
    end
    @(negedge clock);
    e_start = 1'b1; e_signed_op = sop; e_dividend = a; e_divisor = b;
    @(negedge clock);
    e_start = 1'b0;
    k = 0;
    while (!e_done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check({name, ".lat"}, k, elat);
    check({name, ".q"}, e_q, eq);
    check({name, ".r"}, e_r, er);
    check({name, ".dbz"}, e_dbz, edbz);
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] ra, rb, rq, rr;
    logic rd;
    int k, ndone, dk;
    logic [31:0] dq, dr;

    tbl[0] = '{1'b0, 32'd6,          32'd4,          32'h0000_0001, 32'h0000_0002, 1'b0, 33};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
    tbl[2] = '{1'b0, 32'hFFFF_FFF9,  32'h0000_0002,  32'h7FFF_FFFC, 32'h0000_0001, 1'b0, 33};
    tbl[3] = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1};
    tbl[4] = '{1'b0, 32'd9,          32'd3,          32'd3,         32'd0,         1'b0, 33};
    tbl[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 33};

    clear = 1'b0;
    s_start = 1'b0; s_signed_op = 1'b0; s_dividend = '0; s_divisor = '0;
    e_start = 1'b0; e_signed_op = 1'b0; e_dividend = '0; e_divisor = '0;
    #12;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.q", quotient, 32'd0);
    check("rst.r", remainder, 32'd0);
    check("rst.dbz", div_by_zero, 1'b0);
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 6; i++)
      run32($sformatf("tbl%0d", i), tbl[i].sop, tbl[i].a, tbl[i].b,
            tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      case ($urandom % 6)
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom % 100;
        default: ra = $urandom;
      endcase
      case ($urandom % 8)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom % 16;
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      k = int'($urandom % 2);
      model32(k[0], ra, rb, rq, rr, rd);
      run32($sformatf("rnd%0d", i), k[0], ra, rb, rq, rr, rd, rd ? 1 : 33);
    end

    // start pulsed mid-divide must be ignored
    @(negedge clock);
    s_start = 1'b1; s_signed_op = 1'b1; s_dividend = 32'h8000_0000; s_divisor = 32'hFFFF_FFFF;
    @(negedge clock);
    s_start = 1'b0;
    ndone = 0; dk = -1; dq = '0; dr = '0;
    for (k = 0; k < 80; k++) begin
      if (done) begin
        ndone++;
        if (dk < 0) begin dk = k; dq = quotient; dr = remainder; end
      end
      if (k == 5) begin s_start = 1'b1; s_dividend = 32'd1; s_divisor = 32'd1; end
      if (k == 6) s_start = 1'b0;
      @(negedge clock);
    end
    check("busy_start.ndone", ndone, 1);
    check("busy_start.lat", dk, 33);
    check("busy_start.q", dq, 32'h8000_0000);
    check("busy_start.r", dr, 32'd0);

    // asynchronous clear mid-divide
    run32("pre_clr", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    @(negedge clock);
    s_start = 1'b1; s_signed_op = 1'b0; s_dividend = 32'd100; s_divisor = 32'd7;
    @(negedge clock);
    s_start = 1'b0;
    repeat (10) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    check("clr.busy", busy, 1'b0);
    check("clr.done", done, 1'b0);
    check("clr.q", quotient, 32'd0);
    check("clr.r", remainder, 32'd0);
    check("clr.dbz", div_by_zero, 1'b0);
    @(negedge clock);
    clear = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("clr.no_done", ndone, 0);
    run32("post_clr", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    // 8-bit unsigned-only instance, back-to-back start in the done cycle
    @(negedge clock);
    e_start = 1'b1; e_signed_op = 1'b1; e_dividend = 8'hF0; e_divisor = 8'h03;
    @(negedge clock);
    e_start = 1'b0;
    k = 0;
    while (!e_done && k < 100) begin @(negedge clock); k++; end
    check("w8.lat", k, 9);
    check("w8.q", e_q, 8'h50);
    check("w8.r", e_r, 8'h00);
    check("w8.dbz", e_dbz, 1'b0);
    e_start = 1'b1; e_signed_op = 1'b0; e_dividend = 8'h64; e_divisor = 8'h07;
    @(negedge clock);
    e_start = 1'b0;
    check("w8b2b.busy", e_busy, 1'b1);
    k = 0;
    while (!e_done && k < 100) begin @(negedge clock); k++; end
    check("w8b2b.lat", k, 9);
    check("w8b2b.q", e_q, 8'h0E);
    check("w8b2b.r", e_r, 8'h02);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom % 6 == 0) ? 32'd0 : 32'($urandom);
      k = int'($urandom % 2);
      run8($sformatf("r8_%0d", i), k[0], ra[7:0], rb[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
